// File: rtl/monost_pkg.sv
// Shared types and elaboration helpers for the multi-channel monostable.
package monost_pkg;

    typedef enum logic {
        MS_IDLE   = 1'b0,
        MS_ACTIVE = 1'b1
    } ms_state_t;

    // True when the pulse length is at least one cycle and its last count fits the counter.
    function automatic bit wait_time_ok(input longint wait_time, input int cnt_w);
        return (wait_time >= 1) && (cnt_w >= 1) && (cnt_w < 63) &&
               (wait_time < (longint'(1) << cnt_w));
    endfunction

endpackage

// File: rtl/monost_chan.sv
// One monostable channel: rising-edge detect, IDLE/ACTIVE FSM, up-counter and expiry strobe.
module monost_chan
    import monost_pkg::*;
#(
    parameter int CNT_W     = 24,
    parameter int WAIT_TIME = 3500000
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      trig,
    input  logic      retrig_en,
    input  logic      abort,
    output ms_state_t state,
    output logic      done
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WAIT_TIME - 1);

    ms_state_t        state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic             done_nx;
    logic             trig_q;
    logic             trig_rise;

    assign trig_rise = trig & ~trig_q;

    // trig_q resets high so a trigger held through reset release is not seen as an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= MS_IDLE;
            cnt    <= '0;
            trig_q <= 1'b1;
            done   <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            trig_q <= trig;
            done   <= done_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        done_nx  = 1'b0;
        if (abort) begin
            state_nx = MS_IDLE;
            cnt_nx   = '0;
        end else if (state == MS_IDLE) begin
            if (trig_rise) begin
                state_nx = MS_ACTIVE;
                cnt_nx   = '0;
            end
        end else if (trig_rise && retrig_en) begin
            cnt_nx = '0;
        end else if (cnt == LAST_CNT) begin
            // Natural expiry wins over a non-retriggerable edge on the same cycle.
            state_nx = MS_IDLE;
            cnt_nx   = '0;
            done_nx  = 1'b1;
        end else begin
            cnt_nx = cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/monost_multi.sv
// NCH independent monostable channels with a shared output polarity selection.
module monost_multi
    import monost_pkg::*;
#(
    parameter int NCH            = 4,
    parameter int CNT_W          = 24,
    parameter int WAIT_TIME      = 3500000,
    parameter int OUT_ACTIVE_LOW = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NCH-1:0] trig,
    input  logic [NCH-1:0] retrig_en,
    input  logic [NCH-1:0] abort,
    output logic [NCH-1:0] pulse_out,
    output logic [NCH-1:0] busy,
    output logic [NCH-1:0] done
);

    localparam logic POL = (OUT_ACTIVE_LOW != 0);

    if (!wait_time_ok(WAIT_TIME, CNT_W)) begin : g_bad_wait_time
        $error("monost_multi: WAIT_TIME must satisfy 1 <= WAIT_TIME < 2**CNT_W");
    end

    ms_state_t ch_state [NCH];

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        monost_chan #(
            .CNT_W    (CNT_W),
            .WAIT_TIME(WAIT_TIME)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .trig     (trig[i]),
            .retrig_en(retrig_en[i]),
            .abort    (abort[i]),
            .state    (ch_state[i]),
            .done     (done[i])
        );
        assign busy[i] = (ch_state[i] == MS_ACTIVE);
    end

    assign pulse_out = busy ^ {NCH{POL}};

endmodule

// File: tb/tb_monost_multi.sv
// Bench for monost_multi: directed scenarios plus random traffic against a remaining-time model.
module tb_monost_multi;

  localparam int NCH            = 4;
  localparam int CNT_W          = 8;
  localparam int WAIT_TIME      = 5;
  localparam int OUT_ACTIVE_LOW = 1;
  localparam int W              = 3 * NCH;

  logic           clk   = 1'b0;
  logic           rst_n = 1'b0;
  logic [NCH-1:0] trig      = '0;
  logic [NCH-1:0] retrig_en = '0;
  logic [NCH-1:0] abort     = '0;
  logic [NCH-1:0] pulse_out;
  logic [NCH-1:0] busy;
  logic [NCH-1:0] done;

  monost_multi #(
    .NCH           (NCH),
    .CNT_W         (CNT_W),
    .WAIT_TIME     (WAIT_TIME),
    .OUT_ACTIVE_LOW(OUT_ACTIVE_LOW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .trig     (trig),
    .retrig_en(retrig_en),
    .abort    (abort),
    .pulse_out(pulse_out),
    .busy     (busy),
    .done     (done)
  );

  // clock/reset block
  always #5 clk = ~clk;

  // scoreboard state: expected {pulse_out, busy, done} after each clock edge
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_exp;
  int vectors     = 0;
  int miscompares = 0;
  int cycle       = 0;

  // reference model: cycles of pulse remaining per channel (0 = idle)
  int   rem  [NCH];
  logic prev [NCH];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got pulse/busy/done=%h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      rem[i]  = 0;
      prev[i] = 1'b1;
    end
  endtask

  // Apply inputs now and queue the outputs expected after the next rising edge.
  task automatic step_now(input logic [NCH-1:0] t, input logic [NCH-1:0] r, input logic [NCH-1:0] a);
    logic [NCH-1:0] b;
    logic [NCH-1:0] d;
    logic           rise;
    trig      = t;
    retrig_en = r;
    abort     = a;
    for (int i = 0; i < NCH; i++) begin
      rise    = t[i] & ~prev[i];
      prev[i] = t[i];
      d[i]    = 1'b0;
      if (a[i]) begin
        rem[i] = 0;
      end else if (rem[i] == 0) begin
        if (rise) rem[i] = WAIT_TIME;
      end else if (rise && r[i]) begin
        rem[i] = WAIT_TIME;
      end else if (rem[i] == 1) begin
        rem[i] = 0;
        d[i]   = 1'b1;
      end else begin
        rem[i] = rem[i] - 1;
      end
      b[i] = (rem[i] != 0);
    end
    exp_q.push_back({(OUT_ACTIVE_LOW != 0) ? ~b : b, b, d});
  endtask

  task automatic step(input logic [NCH-1:0] t, input logic [NCH-1:0] r, input logic [NCH-1:0] a);
    @(negedge clk);
    step_now(t, r, a);
  endtask

  task automatic run(input logic [NCH-1:0] t, input logic [NCH-1:0] r, input logic [NCH-1:0] a,
                     input int n);
    repeat (n) step(t, r, a);
  endtask

  // Reset asserted between edges; outputs must clear without waiting for the clock.
  task automatic async_reset(input string name);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check(name, {pulse_out, busy, done}, {{NCH{1'b1}}, {(2 * NCH){1'b0}}});
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step_now(trig, retrig_en, abort);
  endtask

  // monitor
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cycle++;
      if (exp_q.size() > 0) begin
        mon_exp = exp_q.pop_front();
        check($sformatf("cycle%0d", cycle), {pulse_out, busy, done}, mon_exp);
      end
    end
  end

  // driver
  initial begin
    model_reset();
    trig = 4'b1000;
    @(posedge clk);
    #1 check("reset_values", {pulse_out, busy, done}, {{NCH{1'b1}}, {(2 * NCH){1'b0}}});
    @(negedge clk);
    rst_n = 1'b1;
    step_now(4'b1000, 4'b0000, 4'b0000);
    run(4'b1000, 4'b0000, 4'b0000, 6);
    run(4'b0000, 4'b0000, 4'b0000, 4);

    // basic pulse on channel 0
    step(4'b0001, 4'b0000, 4'b0000);
    run(4'b0000, 4'b0000, 4'b0000, 8);

    // retrigger three cycles in, retriggerable then non-retriggerable
    for (int k = 0; k < 2; k++) begin
      logic [NCH-1:0] r;
      r = (k == 0) ? 4'b0010 : 4'b0000;
      step(4'b0010, r, 4'b0000);
      run(4'b0000, r, 4'b0000, 2);
      step(4'b0010, r, 4'b0000);
      run(4'b0000, r, 4'b0000, 10);
    end

    // edge landing exactly on the expiry cycle
    for (int k = 0; k < 2; k++) begin
      logic [NCH-1:0] r;
      r = (k == 0) ? 4'b0010 : 4'b0000;
      step(4'b0010, r, 4'b0000);
      run(4'b0000, r, 4'b0000, 3);
      step(4'b0010, r, 4'b0000);
      run(4'b0000, r, 4'b0000, 10);
    end

    // abort mid-pulse, then abort coinciding with an edge
    step(4'b0100, 4'b0000, 4'b0000);
    step(4'b0000, 4'b0000, 4'b0000);
    step(4'b0000, 4'b0000, 4'b0100);
    run(4'b0000, 4'b0000, 4'b0000, 7);
    step(4'b0100, 4'b0000, 4'b0100);
    run(4'b0000, 4'b0000, 4'b0000, 7);

    // level held for 20 cycles, then all channels together
    run(4'b0001, 4'b0000, 4'b0000, 20);
    run(4'b0000, 4'b0000, 4'b0000, 3);
    step(4'b1111, 4'b0000, 4'b0000);
    run(4'b0000, 4'b0000, 4'b0000, 8);

    // asynchronous reset in the middle of a pulse
    step(4'b1111, 4'b0000, 4'b0000);
    step(4'b0000, 4'b0000, 4'b0000);
    async_reset("async_reset_mid_pulse");
    run(4'b0000, 4'b0000, 4'b0000, 8);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      logic [NCH-1:0] t, r, a;
      t = NCH'($urandom_range(0, 15));
      r = NCH'($urandom_range(0, 15));
      a = ($urandom_range(0, 11) == 0) ? NCH'($urandom_range(0, 15)) : '0;
      step(t, r, a);
      if ($urandom_range(0, 199) == 0) async_reset("async_reset_random");
    end
    run(4'b0000, 4'b0000, 4'b0000, WAIT_TIME + 2);

    @(posedge clk);
    #2 check("queue_drained", W'(exp_q.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
